// File: rtl/ysyx_23060332_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060332_ifu
// Purpose  : Instruction fetch unit for a multi-cycle core. It issues one fetch
//            request at a time, captures the returned word, presents it to
//            decode and waits for retirement before computing the next PC.
//            Bus errors and misaligned PCs park the unit in a terminal error
//            state until reset.
// Ports    : clk/rst_n            - clock, synchronous active-low reset
//            imem_req_*           - fetch request channel (valid/ready/addr)
//            imem_rsp_*           - fetch response channel (valid/ready/data/err)
//            inst_valid/ready,
//            inst_o/inst_addr     - instruction handed to decode and its PC
//            next_valid,
//            jump_flag/jump_addr  - retirement and redirect from execute
//            fetch_err            - sticky fetch-fault flag
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060332_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr,
  input  logic        next_valid,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  output logic        fetch_err
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_EXEC = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_inst;
  logic [31:0] r_inst_addr;
  logic        r_err;
  logic        w_err_nxt;
  logic        w_capture;

  // State, PC and instruction registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_inst      <= C_NOP;
      r_inst_addr <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_err   <= w_err_nxt;
      if (w_capture) begin
        r_inst      <= imem_rsp_data;
        r_inst_addr <= r_pc;
      end
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_err_nxt      = r_err;
    w_capture      = 1'b0;
    imem_req_valid = 1'b0;
    imem_rsp_ready = 1'b0;
    inst_valid     = 1'b0;

    case (r_state)
      S_IDLE: begin
        // The alignment check is made on the way into REQ so that a
        // misaligned PC never appears as a bus request.
        if (r_pc[1:0] != 2'b00) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        imem_rsp_ready = 1'b1;
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_ERR;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (next_valid) begin
          w_pc_nxt = jump_flag ? jump_addr : (r_pc + 32'd4);
          if (w_pc_nxt[1:0] != 2'b00) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_req_addr = r_pc;
  assign inst_o        = r_inst;
  assign inst_addr     = r_inst_addr;
  assign fetch_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060332_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060332_ifu
// Purpose  : Self-checking bench for the fetch unit: a table of per-cycle
//            vectors for the zero-wait loop, hand-written corner sequences
//            (stalls, bus error, misaligned jump, reset mid-fetch) and a
//            randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060332_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_addr;
  logic        next_valid;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        fetch_err;

  int n_chk = 0;
  int n_err = 0;

  ysyx_23060332_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_o         (inst_o),
    .inst_addr      (inst_addr),
    .next_valid     (next_valid),
    .jump_flag      (jump_flag),
    .jump_addr      (jump_addr),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic        rr, rv;
    logic [31:0] rd;
    logic        re, ir, nv, jf;
    logic [31:0] ja;
    logic        e_reqv;
    logic [31:0] e_addr;
    logic        e_rspr, e_instv;
    logic [31:0] e_inst, e_iaddr;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
    next_valid     = 1'b0;
    jump_flag      = 1'b0;
    jump_addr      = 32'h0;
  endtask

  task automatic chk_quiet(input string nm, input int idx);
    chk({nm, "_reqv"}, idx, {31'h0, imem_req_valid}, 32'h0);
    chk({nm, "_rspr"}, idx, {31'h0, imem_rsp_ready}, 32'h0);
    chk({nm, "_instv"}, idx, {31'h0, inst_valid}, 32'h0);
  endtask

  // Reset for two edges, check the reset image, release; returns in REQ.
  task automatic do_reset(input int idx);
    clr_in();
    rst_n = 1'b0;
    tick();
    tick();
    chk_quiet("rst", idx);
    chk("rst_err", idx, {31'h0, fetch_err}, 32'h0);
    chk("rst_inst", idx, inst_o, 32'h0000_0013);
    chk("rst_iaddr", idx, inst_addr, 32'h0);
    rst_n = 1'b1;
    tick();
  endtask

  // From REQ, zero-wait fetch of one word and hand-off to decode; returns in EXEC.
  task automatic run_to_exec(input logic [31:0] data);
    clr_in();
    imem_req_ready = 1'b1;
    tick();
    clr_in();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    clr_in();
    inst_ready = 1'b1;
    tick();
    clr_in();
  endtask

  // One zero-wait fetch loop as four table rows. Signals that the current
  // state must ignore are deliberately driven active with junk values.
  task automatic add_loop(input logic [31:0] addr, input logic [31:0] data,
                          input logic jf, input logic [31:0] ja,
                          input logic [31:0] p_inst, input logic [31:0] p_iaddr);
    tbl.push_back('{rr:1'b1, rv:1'b1, rd:32'hDEAD_BEEF, re:1'b0, ir:1'b1, nv:1'b1, jf:1'b1, ja:32'h1234_5670,
                    e_reqv:1'b1, e_addr:addr, e_rspr:1'b0, e_instv:1'b0, e_inst:p_inst, e_iaddr:p_iaddr, e_err:1'b0});
    tbl.push_back('{rr:1'b1, rv:1'b1, rd:data, re:1'b0, ir:1'b1, nv:1'b1, jf:1'b1, ja:32'h1234_5670,
                    e_reqv:1'b0, e_addr:addr, e_rspr:1'b1, e_instv:1'b0, e_inst:p_inst, e_iaddr:p_iaddr, e_err:1'b0});
    tbl.push_back('{rr:1'b1, rv:1'b1, rd:32'hBAD0_BAD0, re:1'b1, ir:1'b1, nv:1'b1, jf:1'b1, ja:32'h1234_5670,
                    e_reqv:1'b0, e_addr:addr, e_rspr:1'b0, e_instv:1'b1, e_inst:data, e_iaddr:addr, e_err:1'b0});
    tbl.push_back('{rr:1'b1, rv:1'b1, rd:32'hBAD1_BAD1, re:1'b1, ir:1'b1, nv:1'b1, jf:jf, ja:ja,
                    e_reqv:1'b0, e_addr:addr, e_rspr:1'b0, e_instv:1'b0, e_inst:data, e_iaddr:addr, e_err:1'b0});
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  initial begin
    logic [31:0] m_pc, pend_addr, exp_inst, exp_iaddr, t;
    logic        pending, have_inst, executing;
    int          retires;

    clr_in();
    rst_n = 1'b0;

    // ---------------- table-driven zero-wait loop ----------------
    add_loop(32'h8000_0000, 32'h0010_0093, 1'b0, 32'h0,          32'h0000_0013, 32'h0);
    add_loop(32'h8000_0004, 32'h0020_0113, 1'b0, 32'h0,          32'h0010_0093, 32'h8000_0000);
    add_loop(32'h8000_0008, 32'h0030_0193, 1'b0, 32'h0,          32'h0020_0113, 32'h8000_0004);
    add_loop(32'h8000_000C, 32'h0040_0213, 1'b1, 32'h8000_0100, 32'h0030_0193, 32'h8000_0008);
    add_loop(32'h8000_0100, 32'h0050_0293, 1'b1, 32'hFFFF_FFFC, 32'h0040_0213, 32'h8000_000C);
    add_loop(32'hFFFF_FFFC, 32'h0060_0313, 1'b0, 32'h0,          32'h0050_0293, 32'h8000_0100);
    tbl.push_back('{rr:1'b0, rv:1'b0, rd:32'h0, re:1'b0, ir:1'b0, nv:1'b0, jf:1'b0, ja:32'h0,
                    e_reqv:1'b1, e_addr:32'h0000_0000, e_rspr:1'b0, e_instv:1'b0,
                    e_inst:32'h0060_0313, e_iaddr:32'hFFFF_FFFC, e_err:1'b0});

    do_reset(0);
    foreach (tbl[i]) begin
      chk("tbl_reqv", i, {31'h0, imem_req_valid}, {31'h0, tbl[i].e_reqv});
      if (tbl[i].e_reqv) chk("tbl_addr", i, imem_req_addr, tbl[i].e_addr);
      chk("tbl_rspr", i, {31'h0, imem_rsp_ready}, {31'h0, tbl[i].e_rspr});
      chk("tbl_instv", i, {31'h0, inst_valid}, {31'h0, tbl[i].e_instv});
      chk("tbl_inst", i, inst_o, tbl[i].e_inst);
      chk("tbl_iaddr", i, inst_addr, tbl[i].e_iaddr);
      chk("tbl_err", i, {31'h0, fetch_err}, {31'h0, tbl[i].e_err});
      imem_req_ready = tbl[i].rr;
      imem_rsp_valid = tbl[i].rv;
      imem_rsp_data  = tbl[i].rd;
      imem_rsp_err   = tbl[i].re;
      inst_ready     = tbl[i].ir;
      next_valid     = tbl[i].nv;
      jump_flag      = tbl[i].jf;
      jump_addr      = tbl[i].ja;
      tick();
    end

    // ---------------- stalls on request and decode ----------------
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hFFFF_0000;
      chk("stall_reqv", k, {31'h0, imem_req_valid}, 32'h1);
      chk("stall_addr", k, imem_req_addr, 32'h8000_0000);
      tick();
    end
    clr_in();
    imem_req_ready = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      clr_in();
      imem_req_ready = 1'b1;
      chk("wait_rspr", k, {31'h0, imem_rsp_ready}, 32'h1);
      chk("wait_reqv", k, {31'h0, imem_req_valid}, 32'h0);
      tick();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00A0_0513;
    tick();
    for (int k = 0; k < 3; k++) begin
      clr_in();
      imem_req_ready = 1'b1;
      chk("hold_instv", k, {31'h0, inst_valid}, 32'h1);
      chk("hold_inst", k, inst_o, 32'h00A0_0513);
      chk("hold_iaddr", k, inst_addr, 32'h8000_0000);
      chk("hold_reqv", k, {31'h0, imem_req_valid}, 32'h0);
      tick();
    end
    clr_in();
    inst_ready = 1'b1;
    tick();
    chk_quiet("exec", 0);

    // ---------------- reset during WAIT ----------------
    do_reset(2);
    run_to_exec(32'h1234_5673);
    next_valid = 1'b1;
    tick();
    chk("rw_addr", 0, imem_req_addr, 32'h8000_0004);
    clr_in();
    imem_req_ready = 1'b1;
    tick();
    chk("rw_rspr", 0, {31'h0, imem_rsp_ready}, 32'h1);
    clr_in();
    rst_n = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h7777_7777;
    tick();
    chk_quiet("rw_idle", 0);
    chk("rw_inst", 0, inst_o, 32'h0000_0013);
    chk("rw_iaddr", 0, inst_addr, 32'h0);
    clr_in();
    rst_n = 1'b1;
    tick();
    chk("rw_reqv", 0, {31'h0, imem_req_valid}, 32'h1);
    chk("rw_pc", 0, imem_req_addr, 32'h8000_0000);

    // ---------------- bus error ----------------
    do_reset(3);
    imem_req_ready = 1'b1;
    tick();
    clr_in();
    imem_rsp_valid = 1'b1;
    imem_rsp_err   = 1'b1;
    imem_rsp_data  = 32'hCAFE_BABE;
    tick();
    for (int k = 0; k < 5; k++) begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_err   = 1'b0;
      inst_ready     = 1'b1;
      next_valid     = 1'b1;
      chk("berr_err", k, {31'h0, fetch_err}, 32'h1);
      chk("berr_inst", k, inst_o, 32'h0000_0013);
      chk_quiet("berr", k);
      tick();
    end
    do_reset(4);

    // ---------------- misaligned jump ----------------
    run_to_exec(32'h0010_0093);
    next_valid = 1'b1;
    jump_flag  = 1'b1;
    jump_addr  = 32'h8000_0102;
    tick();
    for (int k = 0; k < 4; k++) begin
      clr_in();
      imem_req_ready = 1'b1;
      next_valid     = 1'b1;
      chk("mis_err", k, {31'h0, fetch_err}, 32'h1);
      chk_quiet("mis", k);
      tick();
    end
    do_reset(5);

    // ---------------- randomized run vs reference model ----------------
    m_pc      = 32'h8000_0000;
    pend_addr = 32'h0;
    exp_inst  = 32'h0;
    exp_iaddr = 32'h0;
    pending   = 1'b0;
    have_inst = 1'b0;
    executing = 1'b0;
    retires   = 0;
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      imem_rsp_valid = ($urandom_range(0, 2) != 0);
      if (imem_rsp_ready) begin
        imem_rsp_data = memf(pend_addr);
        imem_rsp_err  = 1'b0;
      end else begin
        imem_rsp_data = $urandom;
        imem_rsp_err  = 1'($urandom_range(0, 1));
      end
      inst_ready = ($urandom_range(0, 2) != 0);
      next_valid = ($urandom_range(0, 2) != 0);
      jump_flag  = ($urandom_range(0, 3) == 0);
      t = $urandom;
      t[1:0] = 2'b00;
      jump_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : t;

      chk("rnd_err", c, {31'h0, fetch_err}, 32'h0);
      if (inst_valid) begin
        chk("rnd_instv", c, {31'h0, have_inst}, 32'h1);
        chk("rnd_inst", c, inst_o, exp_inst);
        chk("rnd_iaddr", c, inst_addr, exp_iaddr);
      end
      if (imem_req_valid) begin
        chk("rnd_busy", c, {29'h0, pending, have_inst, executing}, 32'h0);
        chk("rnd_addr", c, imem_req_addr, m_pc);
      end
      if (imem_rsp_ready && imem_rsp_valid)
        chk("rnd_pend", c, {31'h0, pending}, 32'h1);

      if (executing && next_valid) begin
        m_pc      = jump_flag ? jump_addr : (m_pc + 32'd4);
        executing = 1'b0;
        retires++;
      end
      if (inst_valid && inst_ready) begin
        have_inst = 1'b0;
        executing = 1'b1;
      end
      if (imem_rsp_ready && imem_rsp_valid) begin
        pending   = 1'b0;
        have_inst = 1'b1;
        exp_inst  = memf(pend_addr);
        exp_iaddr = pend_addr;
      end
      if (imem_req_valid && imem_req_ready) begin
        pending   = 1'b1;
        pend_addr = imem_req_addr;
      end
      tick();
    end
    chk("rnd_progress", 0, {31'h0, (retires >= 50)}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
